// File: rtl/matrix_result_tx.sv
// Serializes a latched matrix into signed decimal ASCII, one row per line,
// over a valid/ready byte handshake toward the UART transmitter.
module matrix_result_tx #(
  parameter int ELEM_W  = 16,
  parameter int MAX_DIM = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [3:0]                        mat_m,
  input  logic [3:0]                        mat_n,
  input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] mat_flat,
  output logic [7:0]                        tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int NEL = MAX_DIM * MAX_DIM;
  localparam int EIW = $clog2(NEL);

  typedef enum logic [3:0] {IDLE, ERR, LOAD, SIGN, DIGIT, SEP, CR, LF, FIN} state_t;

  state_t                     state, nxt;
  logic [3:0]                 m_q, n_q, row, col;
  logic [EIW-1:0]             eidx;
  logic [ELEM_W*NEL-1:0]      mat_q;
  logic [ELEM_W-1:0]          mag, elem;
  logic                       neg, started;
  logic [2:0]                 pidx;
  logic [16:0]                pow, mag17;
  logic [3:0]                 dcnt;
  logic                       show, bad, can, last_col, last_row, emit;
  logic [7:0]                 ebyte;

  assign elem     = mat_q[int'(eidx)*ELEM_W +: ELEM_W];
  assign mag17    = 17'(mag);
  assign bad      = (mat_m == 4'd0) || (mat_m > 4'(MAX_DIM)) ||
                    (mat_n == 4'd0) || (mat_n > 4'(MAX_DIM));
  // Output register can take a new byte when empty or draining this edge.
  assign can      = !tx_valid || tx_ready;
  assign last_col = (col == n_q - 4'd1);
  assign last_row = (row == m_q - 4'd1);

  always_comb begin
    case (pidx)
      3'd0:    pow = 17'd10000;
      3'd1:    pow = 17'd1000;
      3'd2:    pow = 17'd100;
      3'd3:    pow = 17'd10;
      default: pow = 17'd1;
    endcase
  end

  // Whole digit resolved in one cycle against all multiples of the power,
  // which keeps a frame within its cycle bound for any digit values.
  always_comb begin
    dcnt = '0;
    for (int k = 1; k <= 9; k++)
      if (mag17 >= 17'(k) * pow) dcnt = 4'(k);
  end

  assign show = (dcnt != 4'd0) || started || (pidx == 3'd4);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt   = state;
    emit  = 1'b0;
    ebyte = 8'h00;
    case (state)
      IDLE:  if (start) nxt = bad ? ERR : LOAD;
      ERR:   nxt = IDLE;
      LOAD:  nxt = elem[ELEM_W-1] ? SIGN : DIGIT;
      SIGN:  begin emit = 1'b1; ebyte = 8'h2D; if (can) nxt = DIGIT; end
      DIGIT: begin
        emit  = show;
        ebyte = 8'h30 + {4'd0, dcnt};
        if ((!show || can) && pidx == 3'd4) nxt = last_col ? CR : SEP;
      end
      SEP:   begin emit = 1'b1; ebyte = 8'h20; if (can) nxt = LOAD; end
      CR:    begin emit = 1'b1; ebyte = 8'h0D; if (can) nxt = LF; end
      LF:    begin emit = 1'b1; ebyte = 8'h0A; if (can) nxt = last_row ? FIN : LOAD; end
      FIN:   if (!tx_valid) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // FIN holds until the final LF has left, so done marks true end of frame.
  always_comb begin
    done  = (state == ERR) || (state == FIN && !tx_valid);
    error = (state == ERR);
    busy  = !(state == IDLE || state == ERR || (state == FIN && !tx_valid));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      m_q      <= '0;
      n_q      <= '0;
      mat_q    <= '0;
      row      <= '0;
      col      <= '0;
      eidx     <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      started  <= 1'b0;
      pidx     <= '0;
    end else begin
      if (emit && can) begin
        tx_data  <= ebyte;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
      case (state)
        IDLE: if (start && !bad) begin
          m_q   <= mat_m;
          n_q   <= mat_n;
          mat_q <= mat_flat;
          row   <= '0;
          col   <= '0;
          eidx  <= '0;
        end
        LOAD: begin
          neg     <= elem[ELEM_W-1];
          mag     <= elem[ELEM_W-1] ? (~elem) + ELEM_W'(1) : elem;
          pidx    <= '0;
          started <= 1'b0;
        end
        DIGIT: if (!show || can) begin
          mag     <= ELEM_W'(mag17 - 17'(dcnt) * pow);
          started <= started | show;
          pidx    <= pidx + 3'd1;
        end
        SEP: if (can) begin
          col  <= col + 4'd1;
          eidx <= eidx + EIW'(1);
        end
        LF: if (can) begin
          col  <= '0;
          row  <= row + 4'd1;
          eidx <= eidx + EIW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_tx.sv
// Scoreboard bench for matrix_result_tx: expected ASCII bytes are queued at
// start and popped as the DUT hands bytes over.
module tb_matrix_result_tx;
  localparam int ELEM_W = 16;
  localparam int MAX_DIM = 5;
  localparam int FW = ELEM_W*MAX_DIM*MAX_DIM;

  logic clk = 0, rst_n = 0, start = 0, tx_ready = 1;
  logic [3:0] mat_m = 0, mat_n = 0;
  logic [FW-1:0] mat_flat = '0, flat = '0;
  logic [7:0] tx_data;
  logic tx_valid, busy, done, error;

  int n_chk = 0, n_pass = 0, byte_cnt = 0, done_cnt = 0, frame_base = 0;
  logic [7:0] exp_q[$];
  logic prev_v = 0, prev_x = 0;
  logic [7:0] prev_d = 0;
  bit rand_rdy = 0;

  matrix_result_tx #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_m(mat_m), .mat_n(mat_n),
    .mat_flat(mat_flat), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Byte monitor and handshake-hold checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0; prev_x = 0;
    end else begin
      if (prev_v && !prev_x) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_d);
      end
      if (tx_valid && tx_ready) begin
        byte_cnt++;
        check("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("byte", tx_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
      prev_v = tx_valid; prev_d = tx_data; prev_x = tx_valid && tx_ready;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
  end

  task automatic put(int r, int c, int n, int v);
    flat[(r*n+c)*ELEM_W +: ELEM_W] = ELEM_W'(v);
  endtask

  task automatic model_push(int m, int n);
    logic signed [ELEM_W-1:0] e;
    string s;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        e = flat[(r*n+c)*ELEM_W +: ELEM_W];
        s = $sformatf("%0d", int'(e));
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (c < n-1) exp_q.push_back(8'h20);
        else begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
      end
  endtask

  task automatic send(int m, int n, bit legal);
    mat_m = 4'(m); mat_n = 4'(n); mat_flat = flat;
    if (legal) model_push(m, n);
    frame_base = byte_cnt;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(string tag, int budget, bit exp_err, int exp_len);
    int cyc = 0;
    bit seen = 0, saw_busy = 0, saw_valid = 0;
    while (!seen && cyc < budget) begin
      if (done) seen = 1;
      else begin
        saw_busy |= busy; saw_valid |= tx_valid;
        @(posedge clk); #1; cyc++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy_at_done"}, busy, 0);
    if (exp_err) begin
      check({tag, "_err_latency"}, cyc, 0);
      check({tag, "_no_busy"}, saw_busy, 0);
      check({tag, "_no_valid"}, saw_valid, 0);
    end else begin
      check({tag, "_q_empty"}, exp_q.size(), 0);
      if (exp_len >= 0) check({tag, "_len"}, byte_cnt - frame_base, exp_len);
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int d0;
    #3;
    check("rst_data", tx_data, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    flat = '0; put(0,0,2,1); put(0,1,2,-2); put(1,0,2,30); put(1,1,2,0);
    send(2, 2, 1);
    check("busy_after_start", busy, 1);
    wait_done("m2x2", 12*4+4, 0, 12);

    flat = '0; put(0,0,1,-32768); send(1, 1, 1); wait_done("min", 16, 0, 8);
    flat = '0; put(0,0,1,32767);  send(1, 1, 1); wait_done("max", 16, 0, 7);

    // Backpressure: hold ready low 5 cycles after each of the first two bytes.
    tx_ready = 0;
    flat = '0; put(0,0,3,5); put(0,1,3,6); put(0,2,3,7);
    send(1, 3, 1);
    for (int b = 0; b < 2; b++) begin
      int t = 0;
      while (!tx_valid && t < 50) begin @(posedge clk); #1; t++; end
      check("bp_valid", tx_valid, 1);
      repeat (5) begin @(posedge clk); #1; end
      tx_ready = 1;
      @(posedge clk); #1;
      tx_ready = 0;
    end
    tx_ready = 1;
    wait_done("bp", 200, 0, 7);

    send(0, 3, 0); wait_done("m0", 10, 1, 0);
    send(6, 1, 0); wait_done("m6", 10, 1, 0);

    // Full 5x5 with an ignored mid-frame start carrying different data.
    flat = '0;
    for (int i = 0; i < 25; i++) put(0, i, 25, 32767);
    d0 = done_cnt;
    send(5, 5, 1);
    repeat (20) begin @(posedge clk); #1; end
    mat_m = 2; mat_n = 2; mat_flat = '0;
    start = 1; @(posedge clk); #1; start = 0;
    wait_done("m5x5", 12*25+4-21, 0, 155);
    check("m5x5_done_once", done_cnt - d0, 1);

    flat = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) put(r, c, 4, int'($urandom_range(0, 65535)));
    rand_rdy = 1;
    send(3, 4, 1);
    wait_done("rand", 3000, 0, -1);
    rand_rdy = 0;
    #3 tx_ready = 1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a frame.
    flat = '0;
    for (int i = 0; i < 25; i++) put(0, i, 25, 12345);
    send(5, 5, 1);
    repeat (6) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    #1;
    check("arst_valid", tx_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    flat = '0; put(0,0,1,9); send(1, 1, 1); wait_done("after_rst", 16, 0, 3);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
